// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, streams word reads from a synchronous
// instruction memory and buffers returned words in a two-entry queue for decode.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_fifoData [2];
    logic [ADDR_WIDTH-1:0] r_fifoPc   [2];
    logic                  r_head;
    logic [1:0]            r_count;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflightPc;
    logic                  r_kill;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_wrIdx;
    logic [2:0]            w_credit;

    assign inst_valid = (r_count != 2'd0);
    assign w_pop      = inst_valid & inst_ready;

    // Slots already claimed once this cycle's pop is accounted for; a new read
    // may only be issued if it is guaranteed a free entry when it returns.
    assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = !rst && !redirect_valid && (w_credit < 3'd2);

    // A return landing in a redirect cycle, or marked dead, is dropped.
    assign w_push  = r_inflight && !r_kill && !redirect_valid;
    assign w_wrIdx = r_head ^ r_count[0];

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign inst_data = r_fifoData[r_head];
    assign inst_pc   = r_fifoPc[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_fifoData[0] <= '0;
            r_fifoData[1] <= '0;
            r_fifoPc[0]   <= '0;
            r_fifoPc[1]   <= '0;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_inflight    <= 1'b0;
            r_inflightPc  <= '0;
            r_kill        <= 1'b0;
        end else if (redirect_valid) begin
            r_pc         <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            r_head       <= 1'b0;
            r_count      <= 2'd0;
            r_inflight   <= 1'b0;
            r_kill       <= 1'b1;
        end else begin
            r_kill <= 1'b0;
            if (w_push) begin
                r_fifoData[w_wrIdx] <= imem_rdata;
                r_fifoPc[w_wrIdx]   <= r_inflightPc;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflightPc <= r_pc;
                r_pc         <= r_pc + ADDR_WIDTH'(4);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_sequencer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'hDEADBEEF;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b1;
    logic [31:0]   inst_data;
    logic [AW-1:0] inst_pc;

    int compared   = 0;
    int mismatched = 0;

    fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory holds word n at byte address 4n; idle cycles return garbage
    always @(posedge clk) begin
        imem_rdata <= imem_en ? {22'd0, imem_addr[AW-1:2]} : 32'hDEADBEEF;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [AW-1:0] p, input logic rdy);
        rst            = r;
        redirect_valid = v;
        redirect_pc    = p;
        inst_ready     = rdy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: PC, in-order queue of buffered pcs, one outstanding read
    bit modelOn = 1'b0;
    int mPc;
    int mQ[$];
    bit mInflight;
    int mInflightPc;

    always @(negedge clk) begin
        bit expValid, expEn, pop;
        int expAddr;
        if (modelOn) begin
            expValid = (mQ.size() != 0);
            pop      = expValid && inst_ready;
            expEn    = !rst && !redirect_valid && ((mQ.size() + int'(mInflight) - int'(pop)) < 2);
            expAddr  = mPc;
            checkOutput("model_inst_valid", 32'(inst_valid), 32'(expValid));
            checkOutput("model_imem_en", 32'(imem_en), 32'(expEn));
            checkOutput("model_imem_addr", 32'(imem_addr), 32'(expAddr));
            if (expValid) begin
                checkOutput("model_inst_pc", 32'(inst_pc), 32'(mQ[0]));
                checkOutput("model_inst_data", inst_data, 32'(mQ[0] / 4));
            end
            if (rst) begin
                mPc = 0; mQ.delete(); mInflight = 0;
            end else if (redirect_valid) begin
                mPc = int'(redirect_pc) & ~3; mQ.delete(); mInflight = 0;
            end else begin
                if (pop) void'(mQ.pop_front());
                if (mInflight) mQ.push_back(mInflightPc);
                mInflight = expEn;
                if (expEn) begin
                    mInflightPc = mPc;
                    mPc = (mPc + 4) % (1 << AW);
                end
            end
        end else if (rst) begin
            modelOn = 1'b1; mPc = 0; mQ.delete(); mInflight = 0; mInflightPc = 0;
        end
    end

    initial begin
        // Reset held for two edges, then check reset values
        applyStimulus(1, 0, '0, 1); tick; tick;
        applyStimulus(1, 0, '0, 1);
        checkOutput("rst_imem_en", 32'(imem_en), 32'd0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst_data", inst_data, 32'd0);
        checkOutput("rst_inst_pc", 32'(inst_pc), 32'd0);
        tick;
        // Cycles 0..4 with ready high
        applyStimulus(0, 0, '0, 1);
        checkOutput("c0_imem_en", 32'(imem_en), 32'd1);
        checkOutput("c0_imem_addr", 32'(imem_addr), 32'd0);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("c1_imem_addr", 32'(imem_addr), 32'd4);
        checkOutput("c1_inst_valid", 32'(inst_valid), 32'd0);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("c2_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("c2_inst_pc", 32'(inst_pc), 32'd0);
        checkOutput("c2_inst_data", inst_data, 32'd0);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("c3_inst_pc", 32'(inst_pc), 32'd4);
        checkOutput("c3_inst_data", inst_data, 32'd1);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("c4_inst_pc", 32'(inst_pc), 32'd8);
        checkOutput("c4_inst_data", inst_data, 32'd2);
        tick;
        // Backpressure for five cycles: head 12 held, issue stops
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, '0, 0);
            checkOutput("bp_inst_pc", 32'(inst_pc), 32'd12);
            checkOutput("bp_imem_en", 32'(imem_en), 32'd0);
            tick;
        end
        applyStimulus(0, 0, '0, 1);
        checkOutput("bp_resume_pc", 32'(inst_pc), 32'd12);
        checkOutput("bp_resume_en", 32'(imem_en), 32'd1);
        checkOutput("bp_resume_addr", 32'(imem_addr), 32'd20);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("bp_next_pc", 32'(inst_pc), 32'd16);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("bp_next2_pc", 32'(inst_pc), 32'd20);
        tick;
        // Fill the queue, then redirect to 0x103
        applyStimulus(0, 0, '0, 0); tick;
        applyStimulus(0, 0, '0, 0); tick;
        applyStimulus(0, 1, 10'h103, 0);
        checkOutput("redir_imem_en", 32'(imem_en), 32'd0);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("redir_r1_valid", 32'(inst_valid), 32'd0);
        checkOutput("redir_r1_en", 32'(imem_en), 32'd1);
        checkOutput("redir_r1_addr", 32'(imem_addr), 32'h100);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("redir_r2_valid", 32'(inst_valid), 32'd0);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("redir_r3_pc", 32'(inst_pc), 32'h100);
        checkOutput("redir_r3_data", inst_data, 32'h40);
        tick;
        // Back-to-back redirects: last one wins
        applyStimulus(0, 1, 10'h040, 1); tick;
        applyStimulus(0, 1, 10'h080, 1);
        checkOutput("b2b_en", 32'(imem_en), 32'd0);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("b2b_addr", 32'(imem_addr), 32'h080);
        tick;
        applyStimulus(0, 0, '0, 1); tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("b2b_pc", 32'(inst_pc), 32'h080);
        checkOutput("b2b_valid", 32'(inst_valid), 32'd1);
        tick;
        // Wrap around the top of the address space
        applyStimulus(0, 1, 10'h3F8, 1); tick;
        applyStimulus(0, 0, '0, 1); tick;
        applyStimulus(0, 0, '0, 1); tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("wrap_pc0", 32'(inst_pc), 32'h3F8); tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("wrap_pc1", 32'(inst_pc), 32'h3FC); tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("wrap_pc2", 32'(inst_pc), 32'h000); tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("wrap_pc3", 32'(inst_pc), 32'h004); tick;
        // Reset mid-stream together with a redirect
        applyStimulus(1, 1, 10'h200, 1);
        checkOutput("midrst_en", 32'(imem_en), 32'd0);
        tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("midrst_valid", 32'(inst_valid), 32'd0);
        checkOutput("midrst_pc", 32'(inst_pc), 32'd0);
        checkOutput("midrst_data", inst_data, 32'd0);
        checkOutput("midrst_addr", 32'(imem_addr), 32'd0);
        checkOutput("midrst_imem_en", 32'(imem_en), 32'd1);
        tick;
        applyStimulus(0, 0, '0, 1); tick;
        applyStimulus(0, 0, '0, 1);
        checkOutput("midrst_first_pc", 32'(inst_pc), 32'd0);
        checkOutput("midrst_first_valid", 32'(inst_valid), 32'd1);
        tick;
        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(99) == 0), ($urandom_range(19) == 0),
                          AW'($urandom), ($urandom_range(9) < 7));
            tick;
        end
        applyStimulus(0, 0, '0, 1); tick; tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
